// File: rtl/present_pkg.sv
// PRESENT-80 shared definitions: widths, FSM encoding, S-box table and the
// combinational round primitives. The encrypt core and the decrypt path both
// use these, so player_fwd and player_inv must stay exact inverses.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 80;
  localparam int RC_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_e;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[x];
  endfunction

  // Nibble n occupies bits [4n+3:4n]; all 16 boxes are applied in parallel.
  function automatic logic [BLOCK_W-1:0] sbox_layer64(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Input bit i lands on output bit (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [BLOCK_W-1:0] player_fwd(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Gathers from the same positions player_fwd scatters to.
  function automatic logic [BLOCK_W-1:0] player_inv(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[i] = x[(16*i) % 63];
    end
    y[63] = x[63];
    return y;
  endfunction

  // Key schedule step: rotate left 61, S-box the top nibble, fold in round counter.
  function automatic logic [KEY_W-1:0] key_update80(input logic [KEY_W-1:0] k,
                                                    input logic [RC_W-1:0]  rc);
    logic [KEY_W-1:0] t;
    t          = {k[18:0], k[79:19]};
    t[79:76]   = sbox4(t[79:76]);
    t[19:15]   = t[19:15] ^ rc;
    return t;
  endfunction

endpackage

// File: rtl/present_pbox_encrypt.sv
// Forward PRESENT bit permutation (pLayer), purely combinational.
// Ports:
//   din  [63:0]  block before permutation
//   dout [63:0]  block after permutation
module present_pbox_encrypt
  import present_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  assign dout = player_fwd(din);

endmodule

// File: rtl/present_encrypt_core.sv
// Iterative PRESENT-80 encryption: one round (addRoundKey, S-box layer,
// pLayer) per clock, then a final key whitening cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start             encrypt request, honoured only while ready
//   plaintext [63:0]  block captured on the accept edge
//   key       [79:0]  cipher key captured on the accept edge
//   ready             core idle and able to accept start
//   busy              rounds or final whitening in progress
//   done              one-cycle completion pulse
//   ciphertext [63:0] last result, held until next completion or reset
module present_encrypt_core
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [BLOCK_W-1:0] ciphertext
);

  fsm_e               fsm_q,   fsm_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [KEY_W-1:0]   key_q,   key_d;
  logic [RC_W-1:0]    rc_q,    rc_d;
  logic [BLOCK_W-1:0] ct_q,    ct_d;
  logic               done_q,  done_d;

  logic [BLOCK_W-1:0] sbox_out;
  logic [BLOCK_W-1:0] round_out;
  logic [KEY_W-1:0]   key_next;

  // Round datapath: round key is the top 64 bits of the key register.
  assign sbox_out = sbox_layer64(state_q ^ key_q[79:16]);

  present_pbox_encrypt u_pbox (
    .din  (sbox_out),
    .dout (round_out)
  );

  assign key_next = key_update80(key_q, rc_q);

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    rc_d    = rc_q;
    ct_d    = ct_q;
    done_d  = 1'b0;
    case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = plaintext;
          key_d   = key;
          rc_d    = RC_W'(1);
          fsm_d   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        state_d = round_out;
        key_d   = key_next;
        // rc stops at ROUNDS so it never wraps inside one operation.
        if (rc_q == RC_W'(ROUNDS)) begin
          fsm_d = ST_FINAL;
        end else begin
          rc_d = rc_q + RC_W'(1);
        end
      end
      ST_FINAL: begin
        ct_d   = state_q ^ key_q[79:16];
        done_d = 1'b1;
        fsm_d  = ST_IDLE;
      end
      default: begin
        fsm_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      state_q <= '0;
      key_q   <= '0;
      rc_q    <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      rc_q    <= rc_d;
      ct_q    <= ct_d;
      done_q  <= done_d;
    end
  end

  // done rises the cycle the FSM is back in IDLE, so ready and done overlap.
  assign ready      = (fsm_q == ST_IDLE);
  assign busy       = (fsm_q != ST_IDLE);
  assign done       = done_q;
  assign ciphertext = ct_q;

endmodule

// File: tb/tb_present_encrypt_core.sv
// Bench for present_encrypt_core: a cycle-level reference (edge counting plus a
// plain-arithmetic PRESENT-80 function) checked every cycle, known-answer
// vectors, back-to-back, ignored starts, mid-operation reset, and a pLayer
// unit check.
module tb_present_encrypt_core;
  import present_pkg::*;

  localparam bit [3:0] SB_T [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] plaintext;
  logic [79:0] key;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] ciphertext;
  logic [63:0] pb_in;
  logic [63:0] pb_out;

  int vectors     = 0;
  int miscompares = 0;

  present_encrypt_core #(.ROUNDS(31)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .plaintext  (plaintext),
    .key        (key),
    .ready      (ready),
    .busy       (busy),
    .done       (done),
    .ciphertext (ciphertext)
  );

  present_pbox_encrypt u_pbox_chk (
    .din  (pb_in),
    .dout (pb_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Straight PRESENT-80: 31 rounds then whitening with round key 32.
  function automatic logic [63:0] ref_enc(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    s  = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      t = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB_T[t[4*n +: 4]];
      s = '0;
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16*i) % 63] = t[i];
      kk          = {kk[18:0], kk[79:19]};
      kk[79:76]   = SB_T[kk[79:76]];
      kk[19:15]   = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  // Reference timeline: accepted start at edge E, done visible after E+32.
  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int          m_cnt  = 0;
  logic [63:0] m_ct   = '0;
  logic [63:0] m_pend = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_ct   = '0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1'b1;
          m_cnt  = 0;
          m_pend = ref_enc(plaintext, key);
        end
      end else begin
        m_cnt++;
        if (m_cnt == 32) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_ct   = m_pend;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("ready", 80'(ready), 80'(!m_busy));
    chk("busy", 80'(busy), 80'(m_busy));
    chk("done", 80'(done), 80'(m_done));
    chk("ciphertext", 80'(ciphertext), 80'(m_ct));
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [63:0] p, input logic [79:0] k);
    plaintext = p;
    key       = k;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    plaintext = {$urandom, $urandom};
    key       = {16'($urandom), $urandom, $urandom};
  endtask

  // Returns the number of edges after the accept edge until done is seen.
  task automatic wait_done(output int n, input bit junk);
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (junk) start = (n == 5 || n == 20);
      plaintext = {$urandom, $urandom};
      key       = {16'($urandom), $urandom, $urandom};
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    chk("done_seen", 80'(done), 80'(1));
  endtask

  initial begin
    int          n;
    logic [63:0] p;
    logic [79:0] k;
    rst       = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    pb_in     = '0;

    chk("model_kat0", 80'(ref_enc(64'h0, 80'h0)), 80'(64'h5579C1387B228445));
    chk("model_kat1", 80'(ref_enc(64'h0, ONES80)), 80'(64'hE72C46C0F5945049));
    chk("model_kat2", 80'(ref_enc(ONES64, 80'h0)), 80'(64'hA112FFC72F68417B));
    chk("model_kat3", 80'(ref_enc(ONES64, ONES80)), 80'(64'h3333DCD3213210D2));

    pb_in = 64'h2;                 #1; chk("pbox_bit1", 80'(pb_out), 80'(64'h10000));
    pb_in = 64'h10;                #1; chk("pbox_bit4", 80'(pb_out), 80'(64'h2));
    pb_in = 64'h1_0000;            #1; chk("pbox_bit16", 80'(pb_out), 80'(64'h10));
    pb_in = 64'h8000000000000000;  #1; chk("pbox_bit63", 80'(pb_out), 80'(64'h8000000000000000));
    for (int i = 0; i < 1000; i++) begin
      pb_in = {$urandom, $urandom};
      #1;
      chk("pbox_roundtrip", 80'(player_inv(pb_out)), 80'(pb_in));
    end

    @(posedge clk);
    #1;
    chk("rst_ready", 80'(ready), 80'(1));
    chk("rst_busy", 80'(busy), 80'(0));
    chk("rst_done", 80'(done), 80'(0));
    chk("rst_ct", 80'(ciphertext), 80'(0));
    rst = 1'b0;
    idle(2);

    launch(64'h0, 80'h0);
    wait_done(n, 1'b0);
    chk("t1_latency", 80'(n), 80'(32));
    chk("t1_ct", 80'(ciphertext), 80'(64'h5579C1387B228445));

    idle(1);
    launch(64'h0, ONES80);
    wait_done(n, 1'b0);
    chk("t2a_ct", 80'(ciphertext), 80'(64'hE72C46C0F5945049));
    idle(3);
    launch(ONES64, 80'h0);
    wait_done(n, 1'b0);
    chk("t2b_ct", 80'(ciphertext), 80'(64'hA112FFC72F68417B));

    idle(1);
    launch(ONES64, ONES80);
    wait_done(n, 1'b0);
    chk("t3a_ct", 80'(ciphertext), 80'(64'h3333DCD3213210D2));
    chk("t3_ready_in_done", 80'(ready), 80'(1));
    launch(64'h0, 80'h0);
    wait_done(n, 1'b0);
    chk("t3b_latency", 80'(n + 1), 80'(33));
    chk("t3b_ct", 80'(ciphertext), 80'(64'h5579C1387B228445));

    idle(2);
    p = 64'h0123_4567_89AB_CDEF;
    k = 80'h0011_2233_4455_6677_8899;
    launch(p, k);
    wait_done(n, 1'b1);
    chk("t4_latency", 80'(n), 80'(32));
    chk("t4_ct", 80'(ciphertext), 80'(ref_enc(p, k)));
    idle(40);

    launch(64'h0, 80'h0);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready", 80'(ready), 80'(1));
    chk("t5_busy", 80'(busy), 80'(0));
    chk("t5_ct", 80'(ciphertext), 80'(0));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(40);
    chk("t5_no_done", 80'(done), 80'(0));
    launch(64'h0, 80'h0);
    wait_done(n, 1'b0);
    chk("t5_ct_after", 80'(ciphertext), 80'(64'h5579C1387B228445));

    for (int j = 0; j < 25; j++) begin
      idle($urandom_range(0, 3));
      p = {$urandom, $urandom};
      k = {16'($urandom), $urandom, $urandom};
      launch(p, k);
      wait_done(n, 1'($urandom_range(0, 1)));
      chk("rnd_latency", 80'(n), 80'(32));
      chk("rnd_ct", 80'(ciphertext), 80'(ref_enc(p, k)));
    end

    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
